effects_sequencer: RTL

EFFECTS_SEQUENCER -- requirements
Module: effects_sequencer

---
 rtl/effects_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/effects_sequencer.sv
// effects_sequencer
//   Sequences one audio sample at a time through an external fixed-latency
//   effects pipeline. An accepted sample_tick latches the ADC sample and the
//   bypass choice. The block then issues the sample to the pipeline, waits
//   out the pipeline latency, and captures either the pipeline result or the
//   dry sample into dac_sample. dac_valid pulses for one cycle afterwards.
//   A tick that arrives while a sample is in flight is dropped and recorded
//   in the sticky overrun flag. The gain fed to the pipeline ramps toward the
//   requested target by at most RAMP_STEP per processed sample.
//
// Parameters
//   SLEN          sample width (two's complement)
//   GAIN_W        gain word width
//   PIPE_LATENCY  pipeline latency in clocks, 2..15
//   RAMP_STEP     maximum gain change per processed sample, >= 1
//   GAIN_RESET    gain and gain target value after reset
//
// Ports
//   clk              in   clock
//   rst              in   asynchronous active-low reset
//   en               in   accept new sample ticks
//   bypass           in   deliver dry sample instead of pipeline result
//   sample_tick      in   one-cycle strobe, sample_adc valid
//   sample_adc       in   input sample
//   gain_target      in   requested gain
//   gain_wr          in   load gain_target into the target register
//   overrun_clr      in   clear the overrun flag
//   pipe_valid       out  issue strobe to the effects pipeline
//   pipe_sample_in   out  sample to the pipeline
//   pipe_gain        out  gain to the pipeline
//   pipe_sample_out  in   pipeline result
//   dac_valid        out  one-cycle strobe, dac_sample valid
//   dac_sample       out  processed sample
//   busy             out  a sample is in flight
//   overrun          out  sticky, a tick was lost
//   gain_settled     out  pipe_gain equals the gain target

module effects_sequencer #(
    parameter int SLEN         = 16,
    parameter int GAIN_W       = 10,
    parameter int PIPE_LATENCY = 4,
    parameter int RAMP_STEP    = 8,
    parameter int GAIN_RESET   = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bypass,
    input  logic              sample_tick,
    input  logic [SLEN-1:0]   sample_adc,
    input  logic [GAIN_W-1:0] gain_target,
    input  logic              gain_wr,
    input  logic              overrun_clr,
    output logic              pipe_valid,
    output logic [SLEN-1:0]   pipe_sample_in,
    output logic [GAIN_W-1:0] pipe_gain,
    input  logic [SLEN-1:0]   pipe_sample_out,
    output logic              dac_valid,
    output logic [SLEN-1:0]   dac_sample,
    output logic              busy,
    output logic              overrun,
    output logic              gain_settled
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    // WAIT counts down from PIPE_LATENCY-2 to 0 inclusive, so it spans
    // PIPE_LATENCY-1 cycles and CAPTURE lands PIPE_LATENCY cycles after ISSUE.
    localparam logic [3:0] CNT_INIT = 4'(PIPE_LATENCY - 2);

    localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_RESET);

    // Ramp step saturated to the gain range so a large RAMP_STEP cannot
    // truncate into a small one.
    localparam int unsigned GAIN_MAX = (32'd1 << GAIN_W) - 32'd1;
    localparam int unsigned STEP_SAT =
        (int'(RAMP_STEP) > int'(GAIN_MAX)) ? GAIN_MAX : int'(RAMP_STEP);
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(STEP_SAT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [SLEN-1:0]   r_sample;
    logic              r_bypass;
    logic              r_dac_valid;
    logic [SLEN-1:0]   r_dac_sample;
    logic              r_overrun;
    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] r_target;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t            w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_accept;
    logic              w_capture;
    logic              w_tick_lost;
    logic              w_gain_up;
    logic [GAIN_W-1:0] w_gain_diff;
    logic [GAIN_W-1:0] w_gain_step;
    logic [GAIN_W-1:0] w_gain_nxt;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sample_tick && en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = CNT_INIT;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A tick is lost whenever it is enabled but a sample is already in flight;
    // ticks with en low are ignored everywhere.
    assign w_tick_lost = sample_tick && en && (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Gain ramp: move toward the target by min(STEP, |target - gain|)
    // ------------------------------------------------------------------
    always_comb begin
        w_gain_up   = (r_target > r_gain);
        w_gain_diff = w_gain_up ? (r_target - r_gain) : (r_gain - r_target);
        w_gain_step = (w_gain_diff > STEP) ? STEP : w_gain_diff;
        w_gain_nxt  = w_gain_up ? (r_gain + w_gain_step) : (r_gain - w_gain_step);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample     <= '0;
            r_bypass     <= 1'b0;
            r_dac_valid  <= 1'b0;
            r_dac_sample <= '0;
            r_gain       <= GAIN_RST;
        end else begin
            // The sample and bypass choice are frozen at accept, so later
            // input changes cannot disturb the sample in flight.
            if (w_accept) begin
                r_sample <= sample_adc;
                r_bypass <= bypass;
            end

            r_dac_valid <= w_capture;

            // The ramp uses the target held before this edge; a gain_wr in
            // the CAPTURE cycle only takes effect on the next capture.
            if (w_capture) begin
                r_dac_sample <= r_bypass ? r_sample : pipe_sample_out;
                r_gain       <= w_gain_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target <= GAIN_RST;
        end else if (gain_wr) begin
            r_target <= gain_target;
        end
    end

    // Setting takes priority over clearing so a lost tick is never hidden.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_tick_lost) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pipe_valid     = (r_state == S_ISSUE);
    assign pipe_sample_in = r_sample;
    assign pipe_gain      = r_gain;
    assign dac_valid      = r_dac_valid;
    assign dac_sample     = r_dac_sample;
    assign busy           = (r_state != S_IDLE);
    assign overrun        = r_overrun;
    assign gain_settled   = (r_gain == r_target);

endmodule
